power_window_monitor: RTL and testbench
=======================================

Name: power_window_monitor

Overview:
Downstream stage of the carry-save adder tree in the power emulator. Each cycle it takes the tree's carry-save pair (vs/vc) and resolves it to a per-cycle power sample. It accumulates samples over a programmable window of N samples and reports window sum, peak, min and sample count. The register-interface block reads these results and raises an event on each window completion.

Parameters:
MAX, 36, width of vs/vc and of a resolved sample (clog2(CGES)+BITS with CGES=13, BITS=32)
WIN_W, 16, width of window length and sample counter
ACC_W, MAX+WIN_W, accumulator width; sized so a window sum can never overflow

Ports:
clk  in  1  clock
reset_n  in  1  synchronous, active-high reset (asserted = 1 despite the name)
p_valid  in  1  vs/vc carry a valid sample this cycle
vs  in  MAX  carry-save sum vector from adder tree
vc  in  MAX  carry-save carry vector from adder tree
win_len  in  WIN_W  samples per window; sampled only on accepted start
start  in  1  begin windowed measurement (1-cycle pulse)
stop  in  1  end measurement, flush partial window (1-cycle pulse)
busy  out  1  state != IDLE
win_valid  out  1  1-cycle pulse: result outputs updated
win_partial  out  1  result came from stop flush, not a full window
win_sum  out  ACC_W  sum of samples in window
win_peak  out  MAX  max sample in window
win_min  out  MAX  min sample in window
win_cnt  out  WIN_W  samples in window

Behaviour:
- Reset (reset_n=1 at posedge) clears all outputs, state and pipeline registers to 0. State goes to IDLE and any in-flight sample is dropped. Reset has priority over all other inputs.
- Stage 1 register: smp = (vs+vc) mod 2^MAX, s1_valid = p_valid & (state==RUN).
  - p_valid is ignored in IDLE and FLUSH.
- Stage 2: accumulate when s1_valid is set.
  - First sample of a window loads acc=smp, peak=min=smp, cnt=1.
  - Later samples: acc+=smp, peak=max, min=min, cnt+=1.
- Latency: the last sample of a window presented with p_valid in cycle t gives win_valid=1 in cycle t+2. Result outputs change only at that edge and hold until the next win_valid.
- Windows run back-to-back with no gap. The sample following a window's last sample starts the next window.
- win_len is latched on an accepted start. win_len=0 is treated as 1.
- FSM:
  - IDLE: start -> RUN; latch len and clear window.
  - RUN: stop -> FLUSH; start is ignored.
  - FLUSH: lasts one cycle so the stage-1 sample is accumulated, then -> IDLE.
    - If cnt>0 at exit, emit win_valid with win_partial=1 in the cycle after FLUSH.
    - If cnt==0, no emission.
- Simultaneous events:
  - stop in the same cycle the window's last sample is accumulated: full window is emitted with win_partial=0, and FLUSH has nothing further to emit.
  - start and stop together in IDLE: start wins, and stop is ignored.
- Full-window emissions always have win_partial=0 and win_cnt=latched len.
- Sample arithmetic wraps modulo 2^MAX. The accumulator never overflows by construction.

Test Plan:
- Full window: reset, then start with win_len=4; vs/vc = (5,5),(15,5),(10,20),(40,0) on consecutive cycles -> 2 cycles after the last sample, win_valid=1 with sum=100, peak=40, min=10, cnt=4, partial=0.
- Back-to-back: win_len=2, continuous samples 1,2,3,4 -> two pulses: sum=3 (peak 2, min 1), then sum=7 (peak 4, min 3). No sample lost between them.
- Partial flush: win_len=8, samples 7,9,11, then stop -> win_valid with sum=27, cnt=3, partial=1. busy deasserts after FLUSH. A later p_valid produces no pulse.
- Carry-save wrap: vs=2^36-1, vc=1, with win_len=0 -> one-sample windows, win_sum=0, peak=min=0, cnt=1.
- Reset mid-window: win_len=4, two samples accepted, then reset_n=1 for one cycle -> all outputs 0, busy=0. A fresh start with 4 samples of 3 gives sum=12 and no residue from before reset.
- Ignored inputs: samples sent in IDLE, and start pulsed during RUN -> no effect on the result and no change to latched win_len.

Source files
------------

// File: rtl/power_window_monitor.sv
// Power window monitor: resolves carry-save samples and
// reports sum, peak, min and count over sample windows.
module power_window_monitor #(
    parameter int MAX   = 36,
    parameter int WIN_W = 16,
    parameter int ACC_W = MAX + WIN_W
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             p_valid,
    input  logic [MAX-1:0]   vs,
    input  logic [MAX-1:0]   vc,
    input  logic [WIN_W-1:0] win_len,
    input  logic             start,
    input  logic             stop,
    output logic             busy,
    output logic             win_valid,
    output logic             win_partial,
    output logic [ACC_W-1:0] win_sum,
    output logic [MAX-1:0]   win_peak,
    output logic [MAX-1:0]   win_min,
    output logic [WIN_W-1:0] win_cnt
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_FLUSH = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIN_W-1:0] len_q, len_d;
    logic [MAX-1:0]   smp_q, smp_d;
    logic             s1_valid_q, s1_valid_d;
    logic [ACC_W-1:0] wacc_q, wacc_d;
    logic [MAX-1:0]   wpk_q, wpk_d;
    logic [MAX-1:0]   wmn_q, wmn_d;
    logic [WIN_W-1:0] wcnt_q, wcnt_d;
    logic             win_valid_q, win_valid_d;
    logic             win_partial_q, win_partial_d;
    logic [ACC_W-1:0] win_sum_q, win_sum_d;
    logic [MAX-1:0]   win_peak_q, win_peak_d;
    logic [MAX-1:0]   win_min_q, win_min_d;
    logic [WIN_W-1:0] win_cnt_q, win_cnt_d;

    logic [ACC_W-1:0] acc_n;
    logic [MAX-1:0]   pk_n;
    logic [MAX-1:0]   mn_n;
    logic [WIN_W-1:0] cnt_n;
    logic             full;
    logic             flush_emit;
    logic             emit;

    // Control FSM and stage-1 carry-save resolution
    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        smp_d      = vs + vc;
        s1_valid_d = p_valid && (state_q == S_RUN);
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                    len_d   = (win_len == '0) ? WIN_W'(1) : win_len;
                end
            end
            S_RUN: begin
                if (stop) state_d = S_FLUSH;
            end
            S_FLUSH: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Stage-2 window accumulation and result emission
    always_comb begin
        acc_n = wacc_q;
        pk_n  = wpk_q;
        mn_n  = wmn_q;
        cnt_n = wcnt_q;
        if (s1_valid_q) begin
            if (wcnt_q == '0) begin
                acc_n = ACC_W'(smp_q);
                pk_n  = smp_q;
                mn_n  = smp_q;
                cnt_n = WIN_W'(1);
            end else begin
                acc_n = wacc_q + ACC_W'(smp_q);
                pk_n  = (smp_q > wpk_q) ? smp_q : wpk_q;
                mn_n  = (smp_q < wmn_q) ? smp_q : wmn_q;
                cnt_n = wcnt_q + WIN_W'(1);
            end
        end
        full       = s1_valid_q && (cnt_n == len_q);
        flush_emit = (state_q == S_FLUSH) && !full && (cnt_n != '0);
        emit       = full || flush_emit;

        wacc_d = acc_n;
        wpk_d  = pk_n;
        wmn_d  = mn_n;
        wcnt_d = cnt_n;
        if (emit || (state_q == S_FLUSH) ||
            ((state_q == S_IDLE) && start)) begin
            wcnt_d = '0;
        end

        win_valid_d   = emit;
        win_partial_d = win_partial_q;
        win_sum_d     = win_sum_q;
        win_peak_d    = win_peak_q;
        win_min_d     = win_min_q;
        win_cnt_d     = win_cnt_q;
        if (emit) begin
            win_partial_d = flush_emit;
            win_sum_d     = acc_n;
            win_peak_d    = pk_n;
            win_min_d     = mn_n;
            win_cnt_d     = cnt_n;
        end
    end

    // All state registers with synchronous active-high reset
    always_ff @(posedge clk) begin
        if (reset_n) begin
            state_q       <= S_IDLE;
            len_q         <= '0;
            smp_q         <= '0;
            s1_valid_q    <= 1'b0;
            wacc_q        <= '0;
            wpk_q         <= '0;
            wmn_q         <= '0;
            wcnt_q        <= '0;
            win_valid_q   <= 1'b0;
            win_partial_q <= 1'b0;
            win_sum_q     <= '0;
            win_peak_q    <= '0;
            win_min_q     <= '0;
            win_cnt_q     <= '0;
        end else begin
            state_q       <= state_d;
            len_q         <= len_d;
            smp_q         <= smp_d;
            s1_valid_q    <= s1_valid_d;
            wacc_q        <= wacc_d;
            wpk_q         <= wpk_d;
            wmn_q         <= wmn_d;
            wcnt_q        <= wcnt_d;
            win_valid_q   <= win_valid_d;
            win_partial_q <= win_partial_d;
            win_sum_q     <= win_sum_d;
            win_peak_q    <= win_peak_d;
            win_min_q     <= win_min_d;
            win_cnt_q     <= win_cnt_d;
        end
    end

    assign busy        = (state_q != S_IDLE);
    assign win_valid   = win_valid_q;
    assign win_partial = win_partial_q;
    assign win_sum     = win_sum_q;
    assign win_peak    = win_peak_q;
    assign win_min     = win_min_q;
    assign win_cnt     = win_cnt_q;

endmodule

// File: tb/tb_power_window_monitor.sv
// Randomized bench for power_window_monitor with a
// queue-based window model and pinned literal scenarios.
module tb_power_window_monitor;

    localparam int MAX   = 36;
    localparam int WIN_W = 16;
    localparam int ACC_W = MAX + WIN_W;

    logic             clk = 1'b0;
    logic             reset_n = 1'b1;
    logic             p_valid = 1'b0;
    logic [MAX-1:0]   vs = '0;
    logic [MAX-1:0]   vc = '0;
    logic [WIN_W-1:0] win_len = '0;
    logic             start = 1'b0;
    logic             stop = 1'b0;
    logic             busy;
    logic             win_valid;
    logic             win_partial;
    logic [ACC_W-1:0] win_sum;
    logic [MAX-1:0]   win_peak;
    logic [MAX-1:0]   win_min;
    logic [WIN_W-1:0] win_cnt;

    power_window_monitor #(.MAX(MAX), .WIN_W(WIN_W), .ACC_W(ACC_W)) dut (
        .clk(clk), .reset_n(reset_n), .p_valid(p_valid),
        .vs(vs), .vc(vc), .win_len(win_len),
        .start(start), .stop(stop), .busy(busy),
        .win_valid(win_valid), .win_partial(win_partial),
        .win_sum(win_sum), .win_peak(win_peak),
        .win_min(win_min), .win_cnt(win_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit              v;
        longint unsigned sum;
        longint unsigned pk;
        longint unsigned mn;
        int              cnt;
        bit              part;
    } ev_t;

    int n_chk  = 0;
    int n_pass = 0;
    bit chk_en = 0;

    // model state
    longint unsigned win_q[$];
    int  m_state = 0;
    int  m_len   = 0;
    ev_t p1;
    ev_t expv;
    bit  exp_busy = 0;
    ev_t pulses[$];

    task automatic chk(input string name,
                       input longint unsigned act,
                       input longint unsigned exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    function automatic ev_t stats(input bit part);
        ev_t e;
        e.v = 1; e.part = part; e.sum = 0;
        e.cnt = win_q.size();
        e.pk = win_q[0]; e.mn = win_q[0];
        foreach (win_q[i]) begin
            e.sum += win_q[i];
            if (win_q[i] > e.pk) e.pk = win_q[i];
            if (win_q[i] < e.mn) e.mn = win_q[i];
        end
        return e;
    endfunction

    task automatic model_step();
        ev_t ev;
        logic [MAX-1:0] s;
        ev = '{default: 0};
        if (reset_n) begin
            win_q.delete();
            m_state = 0; m_len = 0;
            p1 = '{default: 0};
            expv = '{default: 0};
            exp_busy = 0;
            return;
        end
        expv.v = p1.v;
        if (p1.v) begin
            expv.sum = p1.sum; expv.pk = p1.pk; expv.mn = p1.mn;
            expv.cnt = p1.cnt; expv.part = p1.part;
        end
        if (m_state == 1 && p_valid) begin
            s = vs + vc;
            win_q.push_back(longint'(s));
            if (win_q.size() == m_len) begin
                ev = stats(0);
                win_q.delete();
            end
        end
        if (m_state == 1 && stop && win_q.size() > 0) begin
            ev = stats(1);
            win_q.delete();
        end
        p1 = ev;
        case (m_state)
            0: if (start) begin
                m_state = 1;
                m_len = (win_len == 0) ? 1 : int'(win_len);
                win_q.delete();
            end
            1: if (stop) m_state = 2;
            default: m_state = 0;
        endcase
        exp_busy = (m_state != 0);
    endtask

    task automatic tick(input bit rst, input bit pv,
                        input logic [MAX-1:0] a,
                        input logic [MAX-1:0] b,
                        input int wl, input bit st, input bit sp);
        reset_n = rst; p_valid = pv; vs = a; vc = b;
        win_len = wl[WIN_W-1:0]; start = st; stop = sp;
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(0, 0, '0, '0, 0, 0, 0);
    endtask

    task automatic smp(input longint unsigned v);
        tick(0, 1, MAX'(v), '0, 0, 0, 0);
    endtask

    task automatic lit(input int idx, input longint unsigned sum,
                       input longint unsigned pk,
                       input longint unsigned mn,
                       input int cnt, input bit part);
        if (idx >= pulses.size()) begin
            chk("pulse_present", pulses.size(), idx + 1);
        end else begin
            chk("lit_sum", pulses[idx].sum, sum);
            chk("lit_peak", pulses[idx].pk, pk);
            chk("lit_min", pulses[idx].mn, mn);
            chk("lit_cnt", pulses[idx].cnt, cnt);
            chk("lit_part", pulses[idx].part, part);
        end
    endtask

    // compare DUT to model on every cycle, log pulses
    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", busy, exp_busy);
            chk("win_valid", win_valid, expv.v);
            chk("win_partial", win_partial, expv.part);
            chk("win_sum", win_sum, expv.sum);
            chk("win_peak", win_peak, expv.pk);
            chk("win_min", win_min, expv.mn);
            chk("win_cnt", win_cnt, expv.cnt);
            if (win_valid) begin
                pulses.push_back('{1, win_sum, win_peak,
                                   win_min, int'(win_cnt),
                                   win_partial});
            end
        end
    end

    initial begin
        logic [63:0] r1, r2;
        bit rs, pv, st, sp;
        p1 = '{default: 0};
        expv = '{default: 0};
        tick(1, 0, '0, '0, 0, 0, 0);
        tick(1, 0, '0, '0, 0, 0, 0);
        chk_en = 1;
        chk("reset_busy", busy, 0);
        chk("reset_sum", win_sum, 0);
        idle(2);

        // full window
        pulses.delete();
        tick(0, 0, '0, '0, 4, 1, 0);
        tick(0, 1, 36'd5, 36'd5, 0, 0, 0);
        tick(0, 1, 36'd15, 36'd5, 0, 0, 0);
        tick(0, 1, 36'd10, 36'd20, 0, 0, 0);
        tick(0, 1, 36'd40, 36'd0, 0, 0, 0);
        idle(1);
        chk("full_no_early", pulses.size(), 0);
        idle(2);
        lit(0, 100, 40, 10, 4, 0);
        tick(0, 0, '0, '0, 0, 0, 1);
        idle(3);
        chk("full_no_partial", pulses.size(), 1);

        // back-to-back
        pulses.delete();
        tick(0, 0, '0, '0, 2, 1, 0);
        smp(1); smp(2); smp(3); smp(4);
        idle(3);
        chk("b2b_count", pulses.size(), 2);
        lit(0, 3, 2, 1, 2, 0);
        lit(1, 7, 4, 3, 2, 0);
        tick(0, 0, '0, '0, 0, 0, 1);
        idle(3);

        // partial flush
        pulses.delete();
        tick(0, 0, '0, '0, 8, 1, 0);
        smp(7); smp(9); smp(11);
        tick(0, 0, '0, '0, 0, 0, 1);
        idle(3);
        lit(0, 27, 11, 7, 3, 1);
        chk("flush_busy", busy, 0);
        smp(5); idle(3);
        chk("flush_after", pulses.size(), 1);

        // carry-save wrap, win_len=0
        pulses.delete();
        tick(0, 0, '0, '0, 0, 1, 0);
        tick(0, 1, {MAX{1'b1}}, 36'd1, 0, 0, 0);
        idle(3);
        lit(0, 0, 0, 0, 1, 0);
        tick(0, 0, '0, '0, 0, 0, 1);
        idle(3);

        // reset mid-window
        pulses.delete();
        tick(0, 0, '0, '0, 4, 1, 0);
        smp(100); smp(200);
        tick(1, 0, '0, '0, 0, 0, 0);
        chk("rst_busy", busy, 0);
        chk("rst_cnt", win_cnt, 0);
        tick(0, 0, '0, '0, 4, 1, 0);
        smp(3); smp(3); smp(3); smp(3);
        idle(3);
        chk("rst_pulses", pulses.size(), 1);
        lit(0, 12, 3, 3, 4, 0);
        tick(0, 0, '0, '0, 0, 0, 1);
        idle(3);

        // ignored inputs: IDLE samples, start in RUN
        pulses.delete();
        smp(50); smp(60);
        tick(0, 0, '0, '0, 3, 1, 0);
        tick(0, 1, 36'd1, '0, 9, 1, 0);
        smp(2); smp(3); smp(4); smp(5); smp(6);
        idle(3);
        lit(0, 6, 3, 1, 3, 0);
        lit(1, 15, 6, 4, 3, 0);
        tick(0, 0, '0, '0, 0, 0, 1);
        idle(3);

        // start and stop together in IDLE
        tick(0, 0, '0, '0, 2, 1, 1);
        chk("startstop_busy", busy, 1);
        tick(0, 0, '0, '0, 0, 0, 1);
        idle(3);

        // randomized
        for (int c = 0; c < 4000; c++) begin
            r1 = {$urandom(), $urandom()};
            r2 = {$urandom(), $urandom()};
            if ($urandom_range(0, 3) == 0) begin
                r1 = r1 & 64'hff;
                r2 = r2 & 64'hff;
            end
            rs = ($urandom_range(0, 299) == 0);
            pv = ($urandom_range(0, 3) != 0);
            st = ($urandom_range(0, 15) == 0);
            sp = ($urandom_range(0, 29) == 0);
            tick(rs, pv, r1[MAX-1:0], r2[MAX-1:0],
                 int'($urandom_range(0, 6)), st, sp);
        end
        idle(4);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
